// File: rtl/chrono_pkg.sv
// Shared types and constants for the chrono/buzzer sequencing blocks.
package chrono_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KEY   = 2'd0,
    CHIME = 2'd1,
    ALARM = 2'd2
  } mode_t;

  localparam int CHIME_MAX   = 12;
  localparam int ALARM_GROUP = 4;

  // Hour chimes never exceed twelve strokes, whatever the caller asks for.
  function automatic logic [3:0] clamp_strokes(input logic [3:0] n);
    return (n > 4'(CHIME_MAX)) ? 4'(CHIME_MAX) : n;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: one-cycle tick every DIV clocks, restartable via synchronous clr.
module ms_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  // tick depends only on the count so the FSM may feed clr back from it.
  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beep_seq.sv
// Beep envelope sequencer: key click, hourly chime and alarm patterns on buz_en.
// Define BEEP_ALARM_TIMEOUT_EN to make the alarm stop by itself after ALARM_TIMEOUT_S seconds.
module beep_seq
  import chrono_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int KEY_MS          = 100,
  parameter int CHIME_ON_MS     = 200,
  parameter int CHIME_OFF_MS    = 200,
  parameter int ALARM_ON_MS     = 100,
  parameter int ALARM_OFF_MS    = 100,
  parameter int ALARM_GAP_MS    = 600,
  parameter int ALARM_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_req,
  input  logic       chime_req,
  input  logic [3:0] chime_n,
  input  logic       alarm_req,
  input  logic       stop,
  output logic       buz_en,
  output logic       busy,
  output logic       alarm_on
);

  localparam int MS_DIV = CLK_HZ / 1000;

  localparam logic [15:0] KEY_LAST    = 16'(KEY_MS - 1);
  localparam logic [15:0] CH_ON_LAST  = 16'(CHIME_ON_MS - 1);
  localparam logic [15:0] CH_OFF_LAST = 16'(CHIME_OFF_MS - 1);
  localparam logic [15:0] AL_ON_LAST  = 16'(ALARM_ON_MS - 1);
  localparam logic [15:0] AL_OFF_LAST = 16'(ALARM_OFF_MS - 1);
  localparam logic [15:0] AL_GAP_LAST = 16'(ALARM_GAP_MS - 1);

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [15:0] ms_q;
  logic [15:0] phase_last;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  tot_q, tot_d;
  logic        phase_clr;
  logic        pre_clr;
  logic        tick;
  logic        phase_done;
  logic        alarm_act;
  logic        chime_ok;
  logic        timeout;

  assign alarm_act  = (state_q != IDLE) && (mode_q == ALARM);
  assign chime_ok   = chime_req && (chime_n != 4'd0);
  assign pre_clr    = phase_clr || (state_q == IDLE);
  assign phase_done = (state_q != IDLE) && tick && (ms_q == phase_last);

  ms_tick #(
    .DIV(MS_DIV)
  ) u_ms_tick (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .tick(tick)
  );

  always_comb begin
    phase_last = 16'd0;
    case (state_q)
      ON: begin
        case (mode_q)
          KEY:     phase_last = KEY_LAST;
          CHIME:   phase_last = CH_ON_LAST;
          default: phase_last = AL_ON_LAST;
        endcase
      end
      OFF:     phase_last = (mode_q == CHIME) ? CH_OFF_LAST : AL_OFF_LAST;
      GAP:     phase_last = AL_GAP_LAST;
      default: phase_last = 16'd0;
    endcase
  end

`ifdef BEEP_ALARM_TIMEOUT_EN
  // Seconds keep counting across phase changes; the ms tick stays aligned
  // because every phase is a whole number of milliseconds.
  logic [15:0] to_ms_q;
  logic [15:0] to_s_q;

  assign timeout = alarm_act && tick && (to_ms_q == 16'd999) &&
                   (to_s_q == 16'(ALARM_TIMEOUT_S - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_ms_q <= 16'd0;
      to_s_q  <= 16'd0;
    end else if (!alarm_act) begin
      to_ms_q <= 16'd0;
      to_s_q  <= 16'd0;
    end else if (tick) begin
      if (to_ms_q == 16'd999) begin
        to_ms_q <= 16'd0;
        to_s_q  <= to_s_q + 16'd1;
      end else begin
        to_ms_q <= to_ms_q + 16'd1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    tot_d     = tot_q;
    phase_clr = 1'b0;

    if (phase_done) begin
      phase_clr = 1'b1;
      case (state_q)
        ON: begin
          case (mode_q)
            KEY:     state_d = IDLE;
            CHIME:   state_d = (cnt_q == tot_q) ? IDLE : OFF;
            default: state_d = (cnt_q == 4'(ALARM_GROUP)) ? GAP : OFF;
          endcase
        end
        OFF: begin
          state_d = ON;
          cnt_d   = cnt_q + 4'd1;
        end
        GAP: begin
          state_d = ON;
          cnt_d   = 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (timeout) begin
      state_d = IDLE;
    end

    // Requests override pattern progression; priority is stop, alarm, chime, key.
    if (stop) begin
      state_d = IDLE;
    end else if (alarm_req && !alarm_act) begin
      state_d   = ON;
      mode_d    = ALARM;
      cnt_d     = 4'd1;
      phase_clr = 1'b1;
    end else if (chime_ok && ((state_q == IDLE) || (mode_q == KEY))) begin
      state_d   = ON;
      mode_d    = CHIME;
      cnt_d     = 4'd1;
      tot_d     = clamp_strokes(chime_n);
      phase_clr = 1'b1;
    end else if (key_req && (state_q == IDLE)) begin
      state_d   = ON;
      mode_d    = KEY;
      cnt_d     = 4'd1;
      phase_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= KEY;
      cnt_q    <= 4'd0;
      tot_q    <= 4'd0;
      ms_q     <= 16'd0;
      buz_en   <= 1'b0;
      busy     <= 1'b0;
      alarm_on <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      tot_q    <= tot_d;
      buz_en   <= (state_d == ON);
      busy     <= (state_d != IDLE);
      alarm_on <= (state_d != IDLE) && (mode_d == ALARM);
      if (pre_clr) begin
        ms_q <= 16'd0;
      end else if (tick) begin
        ms_q <= ms_q + 16'd1;
      end
    end
  end

endmodule
